lut_table_loader: RTL
=====================

// Module: lut_table_loader
// PURPOSE
//  Runtime-writable counterpart of the fixed LogicNets neuron truth table.
//  - Write side: accepts a neuron truth table as a valid/ready configuration stream and stores it.
//  - Read side: serves registered lookups (fan-in address -> neuron output).
//  - Use: lets a layer's neurons be re-trained/re-loaded without re-synthesis. One instance per reprogrammable neuron.
// PARAMETERS
//  ADDR_W   6   neuron fan-in bits; table depth 2**ADDR_W
//  DATA_W   1   neuron output bits per entry
//  WORD_W   8   config beat width; must be multiple of DATA_W and divide 2**ADDR_W*DATA_W
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  rst_n        in   1       asynchronous active-low reset
//  cfg_valid    in   1       config beat valid
//  cfg_ready    out  1       config beat accepted when valid&ready
//  cfg_data     in   WORD_W  packed truth-table bits
//  cfg_last     in   1       marks final beat of a table
//  cfg_clear    in   1       1-cycle pulse: clears load_err, returns to IDLE
//  in_valid     in   1       lookup request valid
//  in_ready     out  1       lookup accepted when valid&ready
//  in_addr      in   ADDR_W  neuron input vector (table index)
//  out_valid    out  1       lookup result valid
//  out_ready    in   1       downstream accepts result
//  out_data     out  DATA_W  neuron output
//  table_valid  out  1       complete table loaded, lookups enabled
//  load_err     out  1       sticky framing error
// BEHAVIOUR
//  Reset: state IDLE, beat_cnt=0, out_valid=0, out_data=0, table_valid=0, load_err=0. Table RAM contents not reset (undefined until loaded).
//  Sizing: BEATS = 2**ADDR_W*DATA_W/WORD_W (default 8). Beat k, bits [j*DATA_W +: DATA_W] -> entry k*(WORD_W/DATA_W)+j.
//  FSM states: IDLE, LOAD, READY, ERROR.
//   IDLE/READY: accepted beat -> write entries, beat_cnt=1, go LOAD. In READY, table_valid drops the same edge.
//   LOAD: each accepted beat writes its entries and increments beat_cnt.
//    Beat BEATS-1 with cfg_last=1 -> READY, beat_cnt=0, table_valid=1 the next cycle.
//    cfg_last=1 on an earlier beat, or cfg_last=0 on beat BEATS-1 -> ERROR, load_err=1. The offending beat's data is still written.
//   ERROR: cfg_ready=0, in_ready=0. Only cfg_clear or reset leave it: cfg_clear -> IDLE, load_err=0.
//   cfg_clear in any other state -> IDLE, table_valid=0, beat_cnt=0. cfg_clear takes priority over a same-cycle beat, and that beat is NOT accepted.
//  cfg_ready = (state!=ERROR) & ~cfg_clear. It is 0 while rst_n is low.
//  Lookup:
//   in_ready = (state==READY) & ~cfg_valid & (~out_valid | out_ready). Config has priority over lookups.
//   Accepted lookup -> out_data = table[in_addr] registered, out_valid=1 the next cycle. Latency 1 cycle.
//   out_valid/out_data hold stable while out_valid & ~out_ready.
//   Back-to-back lookups sustain 1 per cycle when out_ready=1.
//   A result already in the output register stays valid across a reload start. It reflects pre-reload contents.
//  Reset mid-load: immediate return to reset values; a new full table is required.
//  Index arithmetic: entry index = beat_cnt*(WORD_W/DATA_W)+j. Width is ADDR_W, no overflow because beat_cnt < BEATS. beat_cnt width = clog2(BEATS).
// STRUCTURE
//  Shared package (lut_cfg_pkg):
//   - state enum {IDLE,LOAD,READY,ERROR}
//   - BEATS and beat-counter-width functions
//   - entry-index function
//  Sub-module lut_table_ram: 2**ADDR_W x DATA_W distributed RAM.
//   - Write port: WORD_W/DATA_W entries per cycle.
//   - Read port: one synchronous read.
//   - rom_style/ram_style distributed.
//  Top holds the FSM, beat counter and output register/handshake.
// TESTING
//  1) Reset, load 8 beats 0x01,0x00 x6,0x80, last on beat 7.
//     -> table_valid=1; lookup 0->1, 1->0, 63->1, 62->0, each 1 cycle latency.
//  2) Early last: cfg_last on beat 3.
//     -> load_err=1, state ERROR, cfg_ready=0, in_ready=0; cfg_clear -> load_err=0, table_valid=0.
//  3) Missing last on beat 7.
//     -> load_err=1. A subsequent full valid load after cfg_clear gives correct lookups.
//  4) Back-to-back lookups 0..63 with out_ready held low for 3 cycles mid-stream.
//     -> no dropped or duplicated results; out_data stable while stalled.
//  5) Reload while READY: cfg_valid with in_valid in the same cycle.
//     -> lookup stalls, table_valid drops; after load, addr 0 returns the new value.
//  6) rst_n low at beat 4 of a load.
//     -> all outputs 0 immediately; lookups blocked until a full 8-beat reload.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the runtime-loadable neuron truth table.
package lut_cfg_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, READY, ERROR} lut_state_t;

  function automatic int beats_f(input int addr_w, input int data_w, input int word_w);
    return ((2 ** addr_w) * data_w) / word_w;
  endfunction

  function automatic int beat_cnt_w_f(input int addr_w, input int data_w, input int word_w);
    int b;
    b = beats_f(addr_w, data_w, word_w);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

  // Entry j of beat k lands at k*(entries per beat)+j.
  function automatic int entry_idx_f(input int beat, input int j, input int per_beat);
    return beat * per_beat + j;
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table storage: one config beat (WORD_W/DATA_W entries) written per cycle,
// one registered read per cycle; read result holds when re is low.
module lut_table_ram
  import lut_cfg_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 1,
  parameter int WORD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [beat_cnt_w_f(ADDR_W, DATA_W, WORD_W)-1:0] wbeat,
  input  logic [WORD_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int PER = WORD_W / DATA_W;
  localparam int DEPTH = 2 ** ADDR_W;

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int j = 0; j < PER; j++) begin
        mem[ADDR_W'(entry_idx_f(int'(wbeat), j, PER))] <= wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  // The read register doubles as the lookup output register, so it carries the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lut_table_loader.sv
// Reprogrammable neuron LUT: framed config stream loads the table, lookups return in 1 cycle.
// Config wins over lookups; output register holds under out_ready backpressure.
module lut_table_loader
  import lut_cfg_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 1,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_last,
  input  logic              cfg_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              table_valid,
  output logic              load_err
);

  localparam int BEATS = beats_f(ADDR_W, DATA_W, WORD_W);
  localparam int BCW = beat_cnt_w_f(ADDR_W, DATA_W, WORD_W);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  lut_state_t     state, state_nxt;
  logic [BCW-1:0] beat_cnt, beat_nxt;
  logic           tv_nxt, err_nxt;
  logic           cfg_acc, in_acc;

  assign cfg_ready = rst_n & (state != ERROR) & ~cfg_clear;
  assign cfg_acc   = cfg_valid & cfg_ready;
  assign in_ready  = (state == READY) & ~cfg_valid & (~out_valid | out_ready);
  assign in_acc    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      table_valid <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat_cnt    <= beat_nxt;
      table_valid <= tv_nxt;
      load_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    tv_nxt    = table_valid;
    err_nxt   = load_err;
    if (cfg_clear) begin
      state_nxt = IDLE;
      beat_nxt  = '0;
      tv_nxt    = 1'b0;
      err_nxt   = 1'b0;
    end else if (cfg_acc) begin
      case (state)
        IDLE, READY: begin
          tv_nxt = 1'b0;
          // A table never fits in a single beat, so last on the first beat is a framing error.
          if (cfg_last) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
            beat_nxt  = '0;
          end else begin
            state_nxt = LOAD;
            beat_nxt  = BCW'(1);
          end
        end
        LOAD: begin
          if (beat_cnt == LAST_BEAT) begin
            beat_nxt = '0;
            if (cfg_last) begin
              state_nxt = READY;
              tv_nxt    = 1'b1;
            end else begin
              state_nxt = ERROR;
              err_nxt   = 1'b1;
            end
          end else if (cfg_last) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + BCW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (in_acc) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  lut_table_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_acc),
    .wbeat (beat_cnt),
    .wdata (cfg_data),
    .re    (in_acc),
    .raddr (in_addr),
    .rdata (out_data)
  );

endmodule
